// File: rtl/fast_to_slow_pkg.sv
// Shared types and defaults for the fast-to-slow word handoff.
package fast_to_slow_pkg;

    localparam int unsigned DATA_W = 12;

    typedef logic [DATA_W-1:0] sample_t;

endpackage

// File: rtl/bit_sync.sv
// Single-bit synchronizer: SYNC_STAGES flops clocked by the receiving clock.
module bit_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] chain;

    // Shift the asynchronous input through the chain; bit 0 is the metastable stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
        end
    end

    assign dout = chain[SYNC_STAGES-1];

endmodule

// File: rtl/fast_to_slow_sync.sv
// Last-value word handoff from fast_clk logic to slow_clk consumers.
// slow_clk is oversampled as data; q is reloaded just after each slow_clk
// falling edge so it is long settled by the following slow_clk rise.
module fast_to_slow_sync
    import fast_to_slow_pkg::*;
#(
    parameter int unsigned WIDTH       = DATA_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             fast_clk,
    input  logic             reset,
    input  logic             slow_clk,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             q_upd
);

    logic s_sync;
    logic s_prev;
    logic fall;

    bit_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_slow_sync (
        .clk   (fast_clk),
        .reset (reset),
        .din   (slow_clk),
        .dout  (s_sync)
    );

    // Edge history; cleared with the chain so a high slow_clk at release cannot fake a fall.
    always_ff @(posedge fast_clk) begin
        if (reset) begin
            s_prev <= 1'b0;
        end else begin
            s_prev <= s_sync;
        end
    end

    assign fall = s_prev & ~s_sync;

    // Capture d on a detected slow fall; q_upd marks the cycle after the load.
    always_ff @(posedge fast_clk) begin
        if (reset) begin
            q     <= '0;
            q_upd <= 1'b0;
        end else if (fall) begin
            q     <= d;
            q_upd <= 1'b1;
        end else begin
            q_upd <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fast_to_slow_sync.sv
// Bench for fast_to_slow_sync: directed timeline plus random d traffic,
// checked against a timing-rule reference model.
module tb_fast_to_slow_sync;
    import fast_to_slow_pkg::*;

    localparam int unsigned SYNC = 2;

    logic    fast_clk = 1'b0;
    logic    slow_clk = 1'b0;
    logic    reset    = 1'b1;
    sample_t d        = '0;
    sample_t q;
    logic    q_upd;

    int n_assert = 0;
    int n_fail   = 0;

    fast_to_slow_sync #(
        .WIDTH       (DATA_W),
        .SYNC_STAGES (SYNC)
    ) dut (
        .fast_clk (fast_clk),
        .reset    (reset),
        .slow_clk (slow_clk),
        .d        (d),
        .q        (q),
        .q_upd    (q_upd)
    );

    initial forever #50 fast_clk = ~fast_clk;
    initial forever #500 slow_clk = ~slow_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic wait_until(input longint t);
        #(t - $time);
    endtask

    // Reference model: a slow fall loads the d present at the (SYNC+1)th fast rise
    // after it, unless a reset edge intervenes.
    sample_t exp_q    = '0;
    logic    exp_upd  = 1'b0;
    int      pend     = -1;
    bit      rst_win  = 1'b0;
    int      upd_cnt  = 0;
    longint  q_chg_t  = -1000;
    longint  rise_t   = 0;

    always @(negedge slow_clk) begin
        pend = 0;
        if ($time >= 2000 && !rst_win) check("upd_once_per_period", upd_cnt, 1);
        upd_cnt = 0;
        rst_win = 1'b0;
    end

    always @(posedge fast_clk) begin
        if (reset) begin
            exp_q   = '0;
            exp_upd = 1'b0;
            pend    = -1;
            rst_win = 1'b1;
        end else begin
            exp_upd = 1'b0;
            if (pend >= 0) begin
                pend++;
                if (pend == SYNC + 1) begin
                    exp_q   = d;
                    exp_upd = 1'b1;
                    pend    = -1;
                end
            end
        end
    end

    always @(negedge fast_clk) begin
        check("q_vs_model", q, exp_q);
        check("q_upd_vs_model", q_upd, exp_upd);
        if (q_upd === 1'b1) upd_cnt++;
    end

    always @(q) q_chg_t = $time;

    // q must be quiet for one fast period on each side of every slow rise.
    always @(posedge slow_clk) begin
        rise_t = $time;
        #100;
        check("q_stable_at_rise", (q_chg_t < rise_t - 100) || (q_chg_t > rise_t + 100), 1);
    end

    initial begin
        d     = 12'hEFF;
        reset = 1'b1;

        wait_until(100);
        check("reset_q", q, 12'h000);
        check("reset_q_upd", q_upd, 0);
        wait_until(120);
        reset = 1'b0;

        wait_until(700);
        check("no_load_on_rise", q, 12'h000);
        wait_until(1200);
        check("before_first_load", q, 12'h000);
        wait_until(1300);
        check("first_load_q", q, 12'hEFF);
        check("first_load_upd", q_upd, 1);
        wait_until(1400);
        check("upd_one_cycle", q_upd, 0);
        wait_until(1500);
        check("q_held", q, 12'hEFF);

        wait_until(2500);
        d = 12'hEAE;
        wait_until(3200);
        check("update_before", q, 12'hEFF);
        wait_until(3300);
        check("update_after", q, 12'hEAE);

        wait_until(5000);
        d = 12'hAAA;
        wait_until(5300);
        check("coincident_change", q, 12'hAAA);

        wait_until(6000);
        reset = 1'b1;
        wait_until(6100);
        check("mid_reset_q", q, 12'h000);
        reset = 1'b0;
        wait_until(6900);
        check("pending_fall_dropped", q, 12'h000);
        wait_until(7300);
        check("reload_after_reset", q, 12'hAAA);

        wait_until(7500);
        d = 12'h123;
        wait_until(8200);
        check("last_value_before", q, 12'hAAA);
        wait_until(8300);
        check("last_value_after", q, 12'h123);

        // Random d traffic; several values per slow period are dropped by design.
        while ($time < 30000) begin
            @(negedge fast_clk);
            if ($urandom_range(3) == 0) d = sample_t'($urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
